// File: rtl/instr_sequencer_pkg.sv
// uc_pkg: opcodes, fault codes and sequencer state shared by the microcontroller core.
package uc_pkg;
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_MOV  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;
  localparam logic [1:0] FC_NONE       = 2'b00;
  localparam logic [1:0] FC_ILLEGAL    = 2'b01;
  localparam logic [1:0] FC_TIMEOUT    = 2'b10;
  localparam logic [1:0] FC_WRONG_DONE = 2'b11;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT, S_FAULT} seq_state_t;
  function automatic logic [15:0] op_onehot(input logic [3:0] op);
    return 16'h0001 << op;
  endfunction
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: program-memory, instruction-bus and status signals of the sequencer.
interface instr_sequencer_if #(parameter int PC_W = 8);
  logic run, mem_rd, mem_valid, busy, halted, fault;
  logic [15:0] mem_data, ir, unit_start, unit_done;
  logic [PC_W-1:0] pc;
  logic [1:0] fault_code;
  modport master (
    input  run, mem_data, mem_valid, unit_done,
    output mem_rd, pc, ir, unit_start, busy, halted, fault, fault_code
  );
  modport slave (
    output run, mem_data, mem_valid, unit_done,
    input  mem_rd, pc, ir, unit_start, busy, halted, fault, fault_code
  );
endinterface

// File: rtl/instr_sequencer_timeout_ctr.sv
// seq_timeout_ctr: clear/enable cycle counter that saturates at TIMEOUT-1 and flags it.
module seq_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam int W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign tc_o = cnt_q == W'(TIMEOUT - 1);
  always_comb cnt_d = clr_i ? '0 : (en_i && !tc_o) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/decode/dispatch controller owning PC and IR, one execution unit per instruction.
module instr_sequencer
  import uc_pkg::*;
#(
  parameter int          PC_W      = 8,
  parameter int          TIMEOUT   = 16,
  parameter logic [15:0] UNIT_MASK = 16'h0040
) (
  input logic clk,
  input logic rst,
  instr_sequencer_if.master bus
);
  seq_state_t state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d, ir_bus_q, ir_bus_d, start_q, start_d;
  logic [1:0] fc_q, fc_d;
  logic [3:0] op;
  logic [15:0] op_bit;
  logic tmo;
  assign op = ir_q[15:12];
  assign op_bit = op_onehot(op);
  seq_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk   (clk),
    .rst   (rst),
    .clr_i (state_q != S_EXEC),
    .en_i  (state_q == S_EXEC),
    .tc_o  (tmo)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      ir_q     <= '0;
      ir_bus_q <= '0;
      start_q  <= '0;
      fc_q     <= FC_NONE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      ir_bus_q <= ir_bus_d;
      start_q  <= start_d;
      fc_q     <= fc_d;
    end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    fc_d    = fc_q;
    case (state_q)
      S_IDLE: state_d = bus.run ? S_FETCH : S_IDLE;
      S_FETCH:
        if (bus.mem_valid) begin
          ir_d    = bus.mem_data;
          pc_d    = pc_q + 1'b1;
          state_d = S_DECODE;
        end
      S_DECODE:
        if (op == OP_NOP) state_d = bus.run ? S_FETCH : S_IDLE;
        else if (op == OP_HALT) state_d = S_HALT;
        else if (!UNIT_MASK[op]) begin
          state_d = S_FAULT;
          fc_d    = FC_ILLEGAL;
        end else state_d = S_EXEC;
      S_EXEC:
        // a stray done from another unit outranks our own done in the same cycle
        if (|(bus.unit_done & ~op_bit)) begin
          state_d = S_FAULT;
          fc_d    = FC_WRONG_DONE;
        end else if (|(bus.unit_done & op_bit)) state_d = bus.run ? S_FETCH : S_IDLE;
        else if (tmo) begin
          state_d = S_FAULT;
          fc_d    = FC_TIMEOUT;
        end
      S_HALT: state_d = bus.run ? S_HALT : S_IDLE;
      default: state_d = state_q;
    endcase
    ir_bus_d = state_d == S_EXEC ? ir_q : '0;
    start_d  = (state_q == S_DECODE && state_d == S_EXEC) ? op_bit : '0;
  end
  always_comb begin
    bus.mem_rd     = state_q == S_FETCH;
    bus.pc         = pc_q;
    bus.ir         = ir_bus_q;
    bus.unit_start = start_q;
    bus.busy       = state_q inside {S_FETCH, S_DECODE, S_EXEC};
    bus.halted     = state_q == S_HALT;
    bus.fault      = state_q == S_FAULT;
    bus.fault_code = fc_q;
  end
  a_start_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(bus.unit_start));
  a_ir_only_exec: assert property (@(posedge clk) disable iff (rst) (bus.ir != 16'h0) |-> state_q == S_EXEC);
endmodule
